// File: rtl/sr_latch_bank_ctrl.sv
// sr_latch_bank_ctrl: round-robin set/reset pulse sequencer for a bank of SR latch cells.
// Define SR_BANK_VERIFY_EN to add the Q readback CHECK state and the sticky err flag.
module sr_latch_bank_ctrl #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int PULSE_W = 2,
    parameter int HOLD_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             cmd_a,
    input  logic [IDX_W-1:0] idx_a,
    output logic             gnt_a,
    input  logic             req_b,
    input  logic             cmd_b,
    input  logic [IDX_W-1:0] idx_b,
    output logic             gnt_b,
    output logic [N-1:0]     s_out,
    output logic [N-1:0]     r_out,
    input  logic [N-1:0]     q_in,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int CW = (PULSE_W > HOLD_W) ? $clog2(PULSE_W + 1) : $clog2(HOLD_W + 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
`ifdef SR_BANK_VERIFY_EN
    localparam logic [1:0] S_CHECK = 2'd3;
`endif

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_rr_last;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_s;
    logic [N-1:0]     r_r;
    logic             w_free;
    logic             w_pick_a;
    logic             w_gnt_a;
    logic             w_gnt_b;
    logic             w_cmd;
    logic             w_valid;
    logic [IDX_W-1:0] w_idx;
    logic [N-1:0]     w_mask;

    // rst gates the grant so a held request is never acknowledged while in reset
    assign w_free   = (r_state == S_IDLE) && !r_busy && !rst;
    assign w_pick_a = req_a && (!req_b || r_rr_last);
    assign w_gnt_a  = w_free && w_pick_a;
    assign w_gnt_b  = w_free && req_b && !w_pick_a;
    assign w_cmd    = w_gnt_a ? cmd_a : cmd_b;
    assign w_idx    = w_gnt_a ? idx_a : idx_b;
    assign w_valid  = {1'b0, w_idx} < (IDX_W + 1)'(N);
    assign w_mask   = w_valid ? (N'(1) << w_idx) : '0;

    assign gnt_a = w_gnt_a;
    assign gnt_b = w_gnt_b;
    assign s_out = r_s;
    assign r_out = r_r;
    assign busy  = r_busy;
    assign done  = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rr_last <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_s       <= '0;
            r_r       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= w_gnt_a || w_gnt_b;
                    if (w_gnt_a || w_gnt_b) begin
                        r_state   <= S_PULSE;
                        r_cnt     <= CW'(PULSE_W - 1);
                        r_rr_last <= w_gnt_b;
                        r_s       <= w_cmd ? w_mask : '0;
                        r_r       <= w_cmd ? '0 : w_mask;
                    end
                end
                S_PULSE: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_cnt   <= CW'(HOLD_W - 1);
                        r_s     <= '0;
                        r_r     <= '0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == '0) begin
`ifdef SR_BANK_VERIFY_EN
                        r_state <= S_CHECK;
`else
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef SR_BANK_VERIFY_EN
                S_CHECK: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b1;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef SR_BANK_VERIFY_EN
    logic         r_cmd;
    logic [N-1:0] r_mask;
    logic         r_err;

    // an empty mask means the index was out of range, which always counts as an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd  <= 1'b0;
            r_mask <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_gnt_a || w_gnt_b) begin
                r_cmd  <= w_cmd;
                r_mask <= w_mask;
            end
            if (r_state == S_CHECK && (r_mask == '0 || (|(q_in & r_mask)) != r_cmd))
                r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_q;

    assign w_unused_q = ^q_in;
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// tb_sr_latch_bank_ctrl: randomized and directed bench with a cycle-age reference model
// and a behavioural latch bank driving q_in.
module tb_sr_latch_bank_ctrl;
    localparam int N = 8;
    localparam int IDX_W = 3;
    localparam int P = 2;
    localparam int H = 1;
`ifdef SR_BANK_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int LAT = P + H + 1 + int'(VER);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_a = 1'b0, cmd_a = 1'b0, req_b = 1'b0, cmd_b = 1'b0;
    logic [IDX_W-1:0] idx_a = '0, idx_b = '0;
    logic             gnt_a, gnt_b, busy, done, err;
    logic [N-1:0]     s_out, r_out, q_in;
    logic [N-1:0]     q_lat = '0;
    logic [N-1:0]     force0 = '0;

    int               n_chk = 0, n_pass = 0;
    int               age = -1, na = 0, nb = 0;
    bit               last_b = 1'b1, exp_err = 1'b0, pend = 1'b0, m_cmd = 1'b0, ea, eb;
    logic [IDX_W-1:0] m_idx = '0;
    logic [N-1:0]     oh, es, er;
    bit               log_q[$];

    assign q_in = q_lat & ~force0;

    sr_latch_bank_ctrl #(.N(N), .IDX_W(IDX_W), .PULSE_W(P), .HOLD_W(H)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .cmd_a(cmd_a), .idx_a(idx_a), .gnt_a(gnt_a),
        .req_b(req_b), .cmd_b(cmd_b), .idx_b(idx_b), .gnt_b(gnt_b),
        .s_out(s_out), .r_out(r_out), .q_in(q_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // age counts cycles since the grant cycle: pulse at 1..P, hold after, done at LAT
    always @(negedge clk) begin
        if (rst) begin
            check("rst_out", 32'({gnt_a, gnt_b, busy, done, err, s_out, r_out}), 32'd0);
            age = -1;
            last_b = 1'b1;
            exp_err = 1'b0;
            pend = 1'b0;
        end else begin
            ea = age < 0 && req_a && (!req_b || last_b);
            eb = age < 0 && req_b && !ea;
            oh = '0;
            if (age >= 1 && age <= P) oh[m_idx] = 1'b1;
            es = m_cmd ? oh : '0;
            er = m_cmd ? '0 : oh;
            if (VER && age == LAT) exp_err = exp_err | pend;
            check("gnt", 32'({gnt_a, gnt_b}), 32'({ea, eb}));
            check("busy", 32'(busy), 32'(age >= 1));
            check("done", 32'(done), 32'(age == LAT));
            check("s_out", 32'(s_out), 32'(es));
            check("r_out", 32'(r_out), 32'(er));
            check("err", 32'(err), 32'(exp_err));
            check("excl", 32'(s_out & r_out), 32'd0);
            check("onehot", 32'($countones(s_out | r_out) <= 1), 32'd1);
            q_lat = (q_lat | s_out) & ~r_out;
            if (age == LAT - 1) pend = ((q_lat[m_idx] & ~force0[m_idx]) != m_cmd);
            if (ea || eb) begin
                log_q.push_back(eb);
                last_b = eb;
                m_cmd = ea ? cmd_a : cmd_b;
                m_idx = ea ? idx_a : idx_b;
                age = 1;
                if (ea) na++;
                else nb++;
            end else if (age >= 1) begin
                age = (age == LAT) ? -1 : age + 1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int ops, input bit hold, input bit rnd);
        int base, pa, pb, t;
        base = log_q.size();
        pa = na;
        pb = nb;
        t = 0;
        while (log_q.size() < base + ops && t < 2000) begin
            step(1);
            t++;
            if (rnd) begin
                if (na != pa || !req_a) begin
                    req_a = $urandom_range(0, 2) != 0;
                    cmd_a = 1'($urandom);
                    idx_a = IDX_W'($urandom);
                end
                if (nb != pb || !req_b) begin
                    req_b = $urandom_range(0, 2) != 0;
                    cmd_b = 1'($urandom);
                    idx_b = IDX_W'($urandom);
                end
            end else if (!hold) begin
                if (na != pa) req_a = 1'b0;
                if (nb != pb) req_b = 1'b0;
            end
            pa = na;
            pb = nb;
        end
        check("drive_ops", log_q.size() - base, ops);
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            step(1);
            t++;
        end while (!(age < 0 && !busy) && t < 50);
        check("idle_to", 32'(age < 0 && !busy), 32'd1);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_sr", 32'(s_out | r_out), 32'd0);

        // same index from both sides: A sets first, B resets after, B wins the final state
        log_q.delete();
        req_a = 1'b1; cmd_a = 1'b1; idx_a = 3'd1;
        req_b = 1'b1; cmd_b = 1'b0; idx_b = 3'd1;
        drive(2, 1'b0, 1'b0);
        wait_idle();
        check("ord_ab", 32'(log_q.size() >= 2 ? {log_q[0], log_q[1]} : 2'b11), 32'b01);
        check("q1_final", 32'(q_lat[1]), 32'd0);

        log_q.delete();
        req_a = 1'b1; cmd_a = 1'($urandom); idx_a = IDX_W'($urandom);
        req_b = 1'b1; cmd_b = 1'($urandom); idx_b = IDX_W'($urandom);
        drive(4, 1'b1, 1'b0);
        wait_idle();
        check("alt_abab", 32'(log_q.size() >= 4 ? {log_q[0], log_q[1], log_q[2], log_q[3]} : 4'hf), 32'b0101);

        req_a = 1'b1; cmd_a = 1'b1; idx_a = 3'd3;
        drive(1, 1'b0, 1'b0);
        wait_idle();
        check("q3_set", 32'(q_lat[3]), 32'd1);
        check("err_q3", 32'(err), 32'd0);

        force0 = 8'h20;
        req_a = 1'b1; cmd_a = 1'b1; idx_a = 3'd5;
        drive(1, 1'b0, 1'b0);
        wait_idle();
        check("err_set", 32'(err), 32'(VER));
        force0 = '0;
        drive(6, 1'b0, 1'b1);
        wait_idle();
        check("err_sticky", 32'(err), 32'(VER));

        drive(40, 1'b0, 1'b1);
        wait_idle();

        // reset mid-pulse must clear the drive without a clock edge
        req_a = 1'b1; cmd_a = 1'b1; idx_a = 3'd6;
        step(1);
        req_a = 1'b0;
        check("pre_rst", 32'(s_out), 32'h40);
        #1 rst = 1'b1;
        #1;
        check("rst_s", 32'(s_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step(1);
        rst = 1'b0;
        step(4);
        check("no_replay", 32'(s_out | r_out | {7'd0, busy}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
